// File: rtl/axis_width_downsizer.sv
// AXI4-Stream width downsizer.
//
// Splits each wide input beat into RATIO = S_TDATA_WIDTH / M_TDATA_WIDTH
// narrow slices. Slice 0 holds the least significant bits. Slices above the
// highest slice that carries any keep bit are dropped.
//
// Ports
//   s_aclk         : clock shared by both interfaces, rising edge
//   s_aresetn      : asynchronous active-low reset
//   s_axis_tdata   : wide input beat
//   s_axis_tkeep   : byte qualifiers for the input beat, contiguous from bit 0
//   s_axis_tlast   : last beat of the packet
//   s_axis_tvalid  : input beat valid
//   s_axis_tready  : block can accept an input beat
//   m_axis_tdata   : narrow output slice
//   m_axis_tkeep   : byte qualifiers for the output slice
//   m_axis_tlast   : last slice of the packet
//   m_axis_tvalid  : output slice valid
//   m_axis_tready  : downstream accepts the slice
//
// States
//   state    | meaning
//   ST_EMPTY | no beat held, ready for a new input beat
//   ST_SEND  | beat held, slice idx is being presented downstream

module axis_width_downsizer #(
    parameter int S_TDATA_WIDTH = 512,
    parameter int M_TDATA_WIDTH = 64
) (
    input  logic                       s_aclk,
    input  logic                       s_aresetn,
    input  logic [S_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [S_TDATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                       s_axis_tlast,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    output logic [M_TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic [M_TDATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                       m_axis_tlast,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready
);

    localparam int RATIO = S_TDATA_WIDTH / M_TDATA_WIDTH;
    localparam int KB    = M_TDATA_WIDTH / 8;
    localparam int IDXW  = (RATIO > 1) ? $clog2(RATIO) : 1;

    generate
        if ((S_TDATA_WIDTH % M_TDATA_WIDTH) != 0 || RATIO < 2 || (M_TDATA_WIDTH % 8) != 0) begin : g_bad_params
            $error("axis_width_downsizer: S_TDATA_WIDTH must be a multiple (>=2) of M_TDATA_WIDTH, and M_TDATA_WIDTH a multiple of 8");
        end
    endgenerate

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_SEND  = 1'b1
    } state_t;

    state_t                         state;
    state_t                         state_nxt;
    logic [IDXW-1:0]                idx;
    logic [IDXW-1:0]                idx_nxt;

    logic [RATIO-1:0][M_TDATA_WIDTH-1:0] data_q;
    logic [RATIO-1:0][KB-1:0]            keep_q;
    logic                                last_q;
    logic [IDXW-1:0]                     last_idx_q;

    logic                           ready_en;
    logic [RATIO-1:0][KB-1:0]       s_keep_sl;
    logic [IDXW-1:0]                cap_last_idx;
    logic                           cap_emits;
    logic                           at_last;
    logic                           s_hs;
    logic                           m_hs;

    assign s_keep_sl = s_axis_tkeep;

    // Highest slice with any keep bit set; an all-zero keep yields slice 0.
    always_comb begin
        cap_last_idx = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (|s_keep_sl[i]) begin
                cap_last_idx = IDXW'(i);
            end
        end
    end

    // A beat with no bytes only produces output if it carries the packet end.
    assign cap_emits = (|s_axis_tkeep) | s_axis_tlast;
    assign at_last   = (idx == last_idx_q);

    // ready_en holds tready low during reset and releases it on the first edge.
    assign s_axis_tready = ready_en &
                           ((state == ST_EMPTY) |
                            ((state == ST_SEND) & at_last & m_axis_tready));
    assign s_hs = s_axis_tvalid & s_axis_tready;
    assign m_hs = m_axis_tvalid & m_axis_tready;

    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            state    <= ST_EMPTY;
            idx      <= '0;
            ready_en <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            ready_en <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            ST_EMPTY: begin
                if (s_hs) begin
                    state_nxt = cap_emits ? ST_SEND : ST_EMPTY;
                    idx_nxt   = '0;
                end
            end
            ST_SEND: begin
                if (m_hs) begin
                    if (!at_last) begin
                        idx_nxt = idx + IDXW'(1);
                    end else begin
                        idx_nxt   = '0;
                        state_nxt = (s_hs && cap_emits) ? ST_SEND : ST_EMPTY;
                    end
                end
            end
            default: begin
                state_nxt = ST_EMPTY;
                idx_nxt   = '0;
            end
        endcase
    end

    // The holding register only loads on an input handshake, which can only
    // happen when no slice is pending, so outputs stay stable under stall.
    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            data_q     <= '0;
            keep_q     <= '0;
            last_q     <= 1'b0;
            last_idx_q <= '0;
        end else if (s_hs) begin
            data_q     <= s_axis_tdata;
            keep_q     <= s_axis_tkeep;
            last_q     <= s_axis_tlast;
            last_idx_q <= cap_last_idx;
        end
    end

    always_comb begin
        m_axis_tvalid = (state == ST_SEND);
        m_axis_tdata  = data_q[idx];
        m_axis_tkeep  = keep_q[idx];
        m_axis_tlast  = (state == ST_SEND) & at_last & last_q;
    end

endmodule

// File: tb/tb_axis_width_downsizer.sv
module tb_axis_width_downsizer;

    localparam int SW = 512;
    localparam int MW = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [SW-1:0]   s_data = '0;
    logic [SW/8-1:0] s_keep = '0;
    logic            s_last = 1'b0;
    logic            s_vld = 1'b0;
    logic            s_rdy;
    logic [MW-1:0]   m_data;
    logic [MW/8-1:0] m_keep;
    logic            m_last;
    logic            m_vld;
    logic            m_rdy = 1'b0;

    always #5 clk = ~clk;

    axis_width_downsizer #(
        .S_TDATA_WIDTH(SW),
        .M_TDATA_WIDTH(MW)
    ) dut (
        .s_aclk        (clk),
        .s_aresetn     (rst_n),
        .s_axis_tdata  (s_data),
        .s_axis_tkeep  (s_keep),
        .s_axis_tlast  (s_last),
        .s_axis_tvalid (s_vld),
        .s_axis_tready (s_rdy),
        .m_axis_tdata  (m_data),
        .m_axis_tkeep  (m_keep),
        .m_axis_tlast  (m_last),
        .m_axis_tvalid (m_vld),
        .m_axis_tready (m_rdy)
    );

    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } slice_t;

    typedef struct {
        logic [63:0] keep;
        logic        last;
        int          n;
        logic [7:0]  lk;
        logic        ll;
    } vec_t;

    slice_t      q[$];
    vec_t        tbl[8];
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          mode = 0;
    int          n_out = 0;
    int          first_oc = 0;
    int          last_oc = 0;
    logic [7:0]  last_k = '0;
    logic        last_l = 1'b0;
    logic        stall_prev = 1'b0;
    logic [63:0] pd = '0;
    logic [7:0]  pk = '0;
    logic        pl = 1'b0;
    logic        s_hs = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected slices of one input beat: byte count rounded up to whole slices;
    // an empty last beat still closes the packet with one empty slice.
    task automatic push_beat(input logic [SW-1:0] d, input logic [SW/8-1:0] k, input logic l);
        int     nb;
        int     ns;
        slice_t e;
        nb = 0;
        for (int i = 0; i < SW/8; i++) if (k[i]) nb++;
        ns = (nb + 7) / 8;
        if (ns == 0 && l) begin
            e.d = d[63:0]; e.k = 8'h00; e.l = 1'b1;
            q.push_back(e);
        end
        for (int s = 0; s < ns; s++) begin
            e.d = d[64*s +: 64];
            e.k = k[8*s +: 8];
            e.l = l && (s == ns - 1);
            q.push_back(e);
        end
    endtask

    function automatic logic [SW-1:0] rand_data();
        logic [SW-1:0] r;
        for (int i = 0; i < SW/32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [SW/8-1:0] keep_n(input int nb);
        logic [SW/8-1:0] k;
        k = '0;
        for (int i = 0; i < nb; i++) k[i] = 1'b1;
        return k;
    endfunction

    // One clock cycle: starts just after a falling edge, returns at the next.
    task automatic cycle();
        slice_t e;
        case (mode)
            0:       m_rdy = 1'b1;
            1:       m_rdy = ((cyc % 3) == 0);
            default: m_rdy = 1'($urandom_range(0, 1));
        endcase
        #1;
        chk("m_tvalid", 64'(m_vld), 64'(q.size() != 0));
        chk("s_tready", 64'(s_rdy), 64'((q.size() == 0) || (q.size() == 1 && m_rdy)));
        if (stall_prev) begin
            chk("hold_tvalid", 64'(m_vld), 64'd1);
            chk("hold_tdata", m_data, pd);
            chk("hold_tkeep", 64'(m_keep), 64'(pk));
            chk("hold_tlast", 64'(m_last), 64'(pl));
        end
        if (m_vld && m_rdy && q.size() > 0) begin
            e = q.pop_front();
            chk("slice_tdata", m_data, e.d);
            chk("slice_tkeep", 64'(m_keep), 64'(e.k));
            chk("slice_tlast", 64'(m_last), 64'(e.l));
            n_out++;
            if (n_out == 1) first_oc = cyc;
            last_oc = cyc;
            last_k  = m_keep;
            last_l  = m_last;
        end
        stall_prev = m_vld && !m_rdy;
        pd = m_data; pk = m_keep; pl = m_last;
        s_hs = s_vld && s_rdy;
        if (s_hs) push_beat(s_data, s_keep, s_last);
        @(negedge clk);
        cyc++;
    endtask

    task automatic send_beat(input logic [SW-1:0] d, input logic [SW/8-1:0] k,
                             input logic l, input int gap);
        bit got;
        s_vld = 1'b0;
        for (int g = 0; g < gap; g++) cycle();
        s_data = d; s_keep = k; s_last = l; s_vld = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 300 && !got; t++) begin
            cycle();
            got = s_hs;
        end
        if (!got) chk("send_timeout", 64'd0, 64'd1);
        s_vld = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 300 && (q.size() != 0 || m_vld); t++) cycle();
        chk("drain_empty", 64'(q.size()), 64'd0);
        cycle();
    endtask

    initial begin
        tbl[0] = '{keep: {64{1'b1}},       last: 1'b1, n: 8, lk: 8'hFF, ll: 1'b1};
        tbl[1] = '{keep: 64'h000F_FFFF,    last: 1'b1, n: 3, lk: 8'h0F, ll: 1'b1};
        tbl[2] = '{keep: 64'h03FF,         last: 1'b0, n: 2, lk: 8'h03, ll: 1'b0};
        tbl[3] = '{keep: 64'h0,            last: 1'b0, n: 0, lk: 8'h00, ll: 1'b0};
        tbl[4] = '{keep: 64'h0,            last: 1'b1, n: 1, lk: 8'h00, ll: 1'b1};
        tbl[5] = '{keep: 64'hFF,           last: 1'b1, n: 1, lk: 8'hFF, ll: 1'b1};
        tbl[6] = '{keep: 64'h1,            last: 1'b1, n: 1, lk: 8'h01, ll: 1'b1};
        tbl[7] = '{keep: 64'h01FF,         last: 1'b0, n: 2, lk: 8'h01, ll: 1'b0};

        // Reset values and tready release timing.
        #12;
        chk("rst_tvalid", 64'(m_vld), 64'd0);
        chk("rst_tready", 64'(s_rdy), 64'd0);
        chk("rst_tdata", m_data, 64'd0);
        chk("rst_tkeep", 64'(m_keep), 64'd0);
        chk("rst_tlast", 64'(m_last), 64'd0);
        #8;
        rst_n = 1'b1;
        #1;
        chk("rel_tready_before_edge", 64'(s_rdy), 64'd0);
        @(negedge clk);
        chk("rel_tready_after_edge", 64'(s_rdy), 64'd1);

        // Table of single-beat packets.
        mode = 0;
        for (int v = 0; v < 8; v++) begin
            n_out = 0; last_k = 8'hAA; last_l = 1'b0;
            send_beat(rand_data(), tbl[v].keep, tbl[v].last, 1);
            drain();
            chk($sformatf("tbl%0d_nslice", v), 64'(n_out), 64'(tbl[v].n));
            if (tbl[v].n > 0) begin
                chk($sformatf("tbl%0d_last_tkeep", v), 64'(last_k), 64'(tbl[v].lk));
                chk($sformatf("tbl%0d_last_tlast", v), 64'(last_l), 64'(tbl[v].ll));
            end
        end

        // Full beat with 8 slices on consecutive cycles.
        n_out = 0;
        send_beat(rand_data(), {64{1'b1}}, 1'b1, 0);
        drain();
        chk("full_nslice", 64'(n_out), 64'd8);
        chk("full_consecutive", 64'(last_oc - first_oc), 64'd7);

        // Back-pressure 1,0,0,1,...
        mode = 1; n_out = 0;
        send_beat(rand_data(), {64{1'b1}}, 1'b1, 0);
        drain();
        chk("bp_nslice", 64'(n_out), 64'd8);

        // Streaming 3-beat packet without bubbles.
        mode = 0; n_out = 0;
        send_beat(rand_data(), {64{1'b1}}, 1'b0, 0);
        send_beat(rand_data(), {64{1'b1}}, 1'b0, 0);
        send_beat(rand_data(), 64'h03FF, 1'b1, 0);
        drain();
        chk("stream_nslice", 64'(n_out), 64'd18);
        chk("stream_no_bubble", 64'(last_oc - first_oc), 64'd17);
        chk("stream_last_tkeep", 64'(last_k), 64'h03);
        chk("stream_last_tlast", 64'(last_l), 64'd1);

        // Reset while slice 3 of 8 is presented.
        n_out = 0;
        send_beat(rand_data(), {64{1'b1}}, 1'b1, 0);
        for (int t = 0; t < 50 && n_out < 3; t++) cycle();
        chk("mid_reached_slice3", 64'(n_out), 64'd3);
        chk("mid_valid_before_rst", 64'(m_vld), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tvalid", 64'(m_vld), 64'd0);
        chk("mid_rst_tready", 64'(s_rdy), 64'd0);
        chk("mid_rst_tdata", m_data, 64'd0);
        chk("mid_rst_tlast", 64'(m_last), 64'd0);
        q.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_rel_tready_before_edge", 64'(s_rdy), 64'd0);
        @(negedge clk);
        chk("mid_rel_tvalid", 64'(m_vld), 64'd0);
        n_out = 0;
        send_beat(rand_data(), {64{1'b1}}, 1'b1, 0);
        drain();
        chk("mid_after_nslice", 64'(n_out), 64'd8);

        // Randomized packets with random gaps and random back-pressure.
        mode = 2;
        for (int b = 0; b < 150; b++) begin
            int nb;
            nb = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 64);
            send_beat(rand_data(), keep_n(nb), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_width_downsizer.md
AXIS_WIDTH_DOWNSIZER -- requirements
Module: axis_width_downsizer

Interface
REQ-001 SHALL have parameter S_TDATA_WIDTH, default 512: input stream data width in bits.
REQ-002 SHALL have parameter M_TDATA_WIDTH, default 64: output stream data width in bits.
REQ-003 SHALL reject elaboration unless S_TDATA_WIDTH is an integer multiple (RATIO, at least 2) of M_TDATA_WIDTH, and M_TDATA_WIDTH is a multiple of 8.
REQ-004 SHALL have port s_aclk, input, 1: single clock for both interfaces; one clock, all logic on its rising edge.
REQ-005 SHALL have port s_aresetn, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port s_axis_tdata, input, S_TDATA_WIDTH: wide beat from the upstream packet FIFO master.
REQ-007 SHALL have port s_axis_tkeep, input, S_TDATA_WIDTH/8: byte qualifiers, contiguous from bit 0.
REQ-008 SHALL have port s_axis_tlast, input, 1: last beat of packet.
REQ-009 SHALL have port s_axis_tvalid, input, 1: wide beat valid.
REQ-010 SHALL have port s_axis_tready, output, 1: block can accept a wide beat.
REQ-011 SHALL have port m_axis_tdata, output, M_TDATA_WIDTH: narrow slice.
REQ-012 SHALL have port m_axis_tkeep, output, M_TDATA_WIDTH/8: slice byte qualifiers.
REQ-013 SHALL have port m_axis_tlast, output, 1: last slice of packet.
REQ-014 SHALL have port m_axis_tvalid, output, 1: slice valid.
REQ-015 SHALL have port m_axis_tready, input, 1: downstream accepts slice.

Function
REQ-016 SHALL capture tdata, tkeep and tlast into a holding register on each s_axis handshake (s_axis_tvalid and s_axis_tready both high).
REQ-017 SHALL compute, at capture, NSLICE = 1 + index of the highest slice with any tkeep bit set; a slice is M_TDATA_WIDTH/8 keep bits.
REQ-018 SHALL implement two states: EMPTY (no beat held) and SEND (beat held, slice index IDX valid).
REQ-019 SHALL transition EMPTY->SEND on capture with IDX=0, and assert m_axis_tvalid the cycle after capture (latency 1 cycle).
REQ-020 SHALL drive m_axis_tdata and m_axis_tkeep from slice IDX of the held beat: slice 0 is the least significant bits.
REQ-021 SHALL assert m_axis_tlast only when IDX = NSLICE-1 and the held beat had tlast=1.
REQ-022 SHALL increment IDX on each m_axis handshake while IDX < NSLICE-1.
REQ-023 SHALL, on the handshake of slice NSLICE-1, either capture a new beat (SEND, IDX=0) if s_axis_tvalid is high, or go to EMPTY.
REQ-024 SHALL drive s_axis_tready = (state EMPTY) OR (IDX = NSLICE-1 AND m_axis_tready), so back-to-back beats stream with no bubble.
REQ-025 SHALL hold m_axis_tdata, tkeep, tlast and tvalid stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-026 SHALL consume a non-last input beat whose tkeep is all zero without emitting any slice, and stay/return to EMPTY.
REQ-027 SHALL emit a last input beat whose tkeep is all zero as one slice: tkeep=0, tlast=1, so the packet boundary is preserved.
REQ-028 SHALL not depend on tkeep values of slices at or above NSLICE; such bytes are never emitted.

Reset
REQ-029 SHALL, while s_aresetn=0, force state EMPTY, IDX=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tkeep=0, m_axis_tdata=0, s_axis_tready=0.
REQ-030 SHALL drive s_axis_tready=1 from the first rising edge of s_aclk after s_aresetn deasserts.
REQ-031 SHALL discard any held beat on reset mid-packet; no partial slice is emitted after reset release.

Verification
REQ-032 Full beat: one 512-bit beat, tkeep all ones, tlast=1, m_axis_tready=1 -> 8 slices on 8 consecutive cycles starting 1 cycle after capture, slice k = tdata[64k+63:64k], tkeep=8'hFF, tlast only on slice 7.
REQ-033 Partial last beat: tkeep=64'h0000_0000_000F_FFFF (20 bytes) -> 3 slices, tkeep FF, FF, 0F, tlast on slice 2.
REQ-034 Back-pressure: m_axis_tready toggled 1,0,0,1,... -> slices stalled with data held constant, none duplicated or lost, s_axis_tready low until final slice accepted.
REQ-035 Streaming: 3-beat packet (full, full, 10 bytes), s_axis_tvalid continuous, m_axis_tready=1 -> 18 slices with no idle cycle between slices, tlast only on the 18th with tkeep=8'h03.
REQ-036 Empty beats: non-last beat tkeep=0 -> no output; last beat tkeep=0 -> one slice tkeep=8'h00, tlast=1.
REQ-037 Reset mid-packet: assert s_aresetn=0 during slice 3 of 8 -> m_axis_tvalid falls asynchronously to 0; after release, the next packet starts at slice 0 with no stale data.
